// File: rtl/shared_mem_pkg.sv
// Shared-memory responder package: default sizing and the small index
// helpers shared by the arbiter and the memory front end.
package shared_mem_pkg;

    localparam int NCORES_DEF = 4;
    localparam int DEPTH_DEF  = 64;

    // Byte address to word index; bits above the array size are dropped so
    // addresses alias modulo the memory depth.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int aw);
        return (addr >> 2) & ((32'd1 << aw) - 32'd1);
    endfunction

    function automatic logic [2:0] onehot_to_index(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/shared_mem_resp_if.sv
// Core-array to shared-memory request bus; the core side is the master,
// the shared_mem_resp responder is the slave.
interface shared_mem_resp_if #(parameter int NCORES = 4);

    logic [NCORES-1:0]    sharedMEM;
    logic [NCORES*32-1:0] tosharedADDR;
    logic [NCORES*32-1:0] tosharedDATA;
    logic [NCORES-1:0]    tosharedRD;
    logic [NCORES-1:0]    tosharedWR;
    logic [NCORES*32-1:0] fromsharedDATA;
    logic [NCORES-1:0]    stall;
    logic [NCORES-1:0]    grant;
    logic [15:0]          conflicts;

    modport master (
        output sharedMEM, tosharedADDR, tosharedDATA, tosharedRD, tosharedWR,
        input  fromsharedDATA, stall, grant, conflicts
    );

    modport slave (
        input  sharedMEM, tosharedADDR, tosharedDATA, tosharedRD, tosharedWR,
        output fromsharedDATA, stall, grant, conflicts
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner. Reusable for any shared resource.
module rr_arbiter
    import shared_mem_pkg::*;
#(
    parameter int NCORES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCORES-1:0] req,
    output logic [NCORES-1:0] grant
);

    localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

    logic [PW-1:0] rr;
    logic [PW-1:0] next_rr;
    logic [2:0]    grant_idx;
    logic          found;

    // Nothing is granted while reset is held, so no access can slip through.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (!reset) begin
            for (int k = 0; k < NCORES; k++) begin
                if (!found && req[(int'(rr) + k) % NCORES]) begin
                    grant[(int'(rr) + k) % NCORES] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end

    assign grant_idx = onehot_to_index(8'(grant));

    always_comb begin
        next_rr = rr;
        if (|grant) begin
            next_rr = (int'(grant_idx) == NCORES - 1) ? '0 : PW'(int'(grant_idx) + 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr <= '0;
        else       rr <= next_rr;
    end

endmodule

// File: rtl/shared_mem_resp.sv
// Single-ported shared data memory serving NCORES cores: one round-robin
// grant per cycle, zero-latency reads, writes committed on the clock edge.
module shared_mem_resp
    import shared_mem_pkg::*;
#(
    parameter int NCORES = NCORES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               reset,
    shared_mem_resp_if.slave  bus
);

    logic [31:0]       mem [DEPTH];
    logic [NCORES-1:0] req;
    logic [NCORES-1:0] grant;
    logic [AW-1:0]     core_idx [NCORES];
    logic              wr_en;
    logic [AW-1:0]     wr_idx;
    logic [31:0]       wr_data;
    logic              multi_req;

    assign req = bus.sharedMEM & (bus.tosharedRD | bus.tosharedWR);

    rr_arbiter #(.NCORES(NCORES)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    assign bus.grant = grant;
    assign bus.stall = req & ~grant;

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            core_idx[i] = AW'(word_index(bus.tosharedADDR[i*32 +: 32], AW));
        end
    end

    // A granted access with both strobes is a write and returns zero data.
    always_comb begin
        bus.fromsharedDATA = '0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = '0;
        for (int i = 0; i < NCORES; i++) begin
            if (grant[i]) begin
                if (bus.tosharedWR[i]) begin
                    wr_en   = 1'b1;
                    wr_idx  = core_idx[i];
                    wr_data = bus.tosharedDATA[i*32 +: 32];
                end else begin
                    bus.fromsharedDATA[i*32 +: 32] = mem[core_idx[i]];
                end
            end
        end
    end

    assign multi_req = |(req & (req - NCORES'(1)));

    // Register array rather than a RAM macro because it must clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            bus.conflicts <= '0;
        end else begin
            if (wr_en) mem[wr_idx] <= wr_data;
            if (multi_req && bus.conflicts != 16'hFFFF) bus.conflicts <= bus.conflicts + 16'd1;
        end
    end

endmodule

// File: tb/tb_shared_mem_resp.sv
// Directed self-checking bench for shared_mem_resp with four cores.
module tb_shared_mem_resp;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    shared_mem_resp_if #(.NCORES(4)) bus ();

    shared_mem_resp #(.NCORES(4), .DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_all();
        bus.sharedMEM    = '0;
        bus.tosharedADDR = '0;
        bus.tosharedDATA = '0;
        bus.tosharedRD   = '0;
        bus.tosharedWR   = '0;
    endtask

    task automatic drive_core(input int c, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] data);
        bus.sharedMEM[c]             = 1'b1;
        bus.tosharedRD[c]            = rd;
        bus.tosharedWR[c]            = wr;
        bus.tosharedADDR[c*32 +: 32] = addr;
        bus.tosharedDATA[c*32 +: 32] = data;
    endtask

    // Called just after a rising edge; leaves reset low well before the next one.
    task automatic do_reset();
        reset = 1'b1;
        clear_all();
        #2;
        reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_all();
        drive_core(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive_core(2, 1'b0, 1'b1, 32'h8, 32'h77);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_grant: got %b expected %b", bus.grant, 4'b0000);
        end
        tests_run++;
        if (bus.stall !== 4'b0101) begin
            tests_failed++;
            $display("[TB] FAIL reset_stall: got %b expected %b", bus.stall, 4'b0101);
        end
        tests_run++;
        if (bus.fromsharedDATA !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", bus.fromsharedDATA);
        end
        tests_run++;
        if (bus.conflicts !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_conflicts: got %h expected 0", bus.conflicts);
        end
        next_cycle();
        reset = 1'b0;
        clear_all();
    endtask

    task automatic test_single_core();
        do_reset();
        drive_core(1, 1'b0, 1'b1, 32'h0000_0080, 32'hDEADBEEF);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0010 || bus.stall !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL single_write: grant %b stall %b expected 0010 0000", bus.grant, bus.stall);
        end
        next_cycle();
        drive_core(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0010 || bus.stall !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL single_read_grant: grant %b stall %b expected 0010 0000", bus.grant, bus.stall);
        end
        tests_run++;
        if (bus.fromsharedDATA !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin
            tests_failed++;
            $display("[TB] FAIL single_read_data: got %h expected %h", bus.fromsharedDATA,
                     {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
        end
        next_cycle();
    endtask

    task automatic test_contention();
        logic [3:0] exp_grant;
        do_reset();
        for (int c = 0; c < 4; c++) drive_core(c, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 5; k++) begin
            exp_grant = 4'b0001 << (k % 4);
            @(negedge clk);
            tests_run++;
            if (bus.grant !== exp_grant) begin
                tests_failed++;
                $display("[TB] FAIL contention_grant[%0d]: got %b expected %b", k, bus.grant, exp_grant);
            end
            tests_run++;
            if (bus.stall !== ~exp_grant) begin
                tests_failed++;
                $display("[TB] FAIL contention_stall[%0d]: got %b expected %b", k, bus.stall, ~exp_grant);
            end
            tests_run++;
            if (bus.conflicts !== 16'(k)) begin
                tests_failed++;
                $display("[TB] FAIL contention_conflicts[%0d]: got %0d expected %0d", k, bus.conflicts, k);
            end
            next_cycle();
        end
    endtask

    task automatic test_wrap_alias();
        do_reset();
        drive_core(0, 1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678);
        next_cycle();
        clear_all();
        drive_core(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.fromsharedDATA[31:0] !== 32'h1234_5678) begin
            tests_failed++;
            $display("[TB] FAIL wrap_alias: got %h expected %h", bus.fromsharedDATA[31:0], 32'h1234_5678);
        end
        next_cycle();
    endtask

    task automatic test_rd_wr();
        do_reset();
        drive_core(2, 1'b1, 1'b1, 32'h0000_0040, 32'hA5A5A5A5);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL rdwr_grant: got %b expected %b", bus.grant, 4'b0100);
        end
        tests_run++;
        if (bus.fromsharedDATA !== 128'h0) begin
            tests_failed++;
            $display("[TB] FAIL rdwr_rdata: got %h expected 0", bus.fromsharedDATA);
        end
        next_cycle();
        clear_all();
        drive_core(2, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.fromsharedDATA[95:64] !== 32'hA5A5A5A5) begin
            tests_failed++;
            $display("[TB] FAIL rdwr_written: got %h expected %h", bus.fromsharedDATA[95:64], 32'hA5A5A5A5);
        end
        next_cycle();
    endtask

    task automatic test_skip_hold();
        do_reset();
        drive_core(1, 1'b1, 1'b0, 32'h0, 32'h0);
        next_cycle();
        clear_all();
        drive_core(0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL skip_grant: got %b expected %b", bus.grant, 4'b0001);
        end
        next_cycle();
        clear_all();
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0000 || bus.stall !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL idle_outputs: grant %b stall %b expected 0000 0000", bus.grant, bus.stall);
        end
        next_cycle();
        for (int c = 0; c < 4; c++) drive_core(c, 1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL hold_pointer: got %b expected %b", bus.grant, 4'b0010);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_core(3, 1'b0, 1'b1, 32'h20, 32'h1111_1111);
        next_cycle();
        clear_all();
        drive_core(0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive_core(1, 1'b1, 1'b0, 32'h0, 32'h0);
        next_cycle();
        clear_all();
        drive_core(3, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        reset = 1'b1;
        #1;
        clear_all();
        #1;
        reset = 1'b0;
        tests_run++;
        if (bus.conflicts !== 16'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_conflicts: got %0d expected 0", bus.conflicts);
        end
        next_cycle();
        for (int c = 0; c < 4; c++) drive_core(c, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        tests_run++;
        if (bus.grant !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pointer: got %b expected %b", bus.grant, 4'b0001);
        end
        tests_run++;
        if (bus.fromsharedDATA[31:0] !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_word: got %h expected 0", bus.fromsharedDATA[31:0]);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int c = 0; c < 4; c++) drive_core(c, 1'b1, 1'b0, 32'h0, 32'h0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.conflicts !== 16'hFFFE) begin
            tests_failed++;
            $display("[TB] FAIL sat_before: got %h expected %h", bus.conflicts, 16'hFFFE);
        end
        @(negedge clk);
        tests_run++;
        if (bus.conflicts !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL sat_reach: got %h expected %h", bus.conflicts, 16'hFFFF);
        end
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.conflicts !== 16'hFFFF) begin
            tests_failed++;
            $display("[TB] FAIL sat_hold: got %h expected %h", bus.conflicts, 16'hFFFF);
        end
        next_cycle();
        clear_all();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        clear_all();
        test_reset();
        test_single_core();
        test_contention();
        test_wrap_alias();
        test_rd_wr();
        test_skip_hold();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/shared_mem_resp.md
# shared_mem_resp

Responder end of the cores' shared-memory request interface: a single-ported shared data memory that services up to NCORES single-cycle MIPS cores. Each cycle it grants at most one requesting core through round-robin arbitration, returns read data combinationally to the granted core, commits writes on the clock edge, and holds every losing core in stall. It sits at the top level between the core array and the shared data store.

## Interface
Parameters:
- NCORES, 4, number of attached cores (2..8)
- DEPTH, 64, shared memory size in 32-bit words (power of two)
- AW, log2(DEPTH), word-index width

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- sharedMEM  in  NCORES  per-core shared-region access flag
- tosharedADDR  in  NCORES*32  per-core byte address; core i occupies bits [32i+31:32i]
- tosharedDATA  in  NCORES*32  per-core write data
- tosharedRD  in  NCORES  per-core read strobe
- tosharedWR  in  NCORES  per-core write strobe
- fromsharedDATA  out  NCORES*32  per-core read data
- stall  out  NCORES  per-core hold request; the core freezes its PC and suppresses writeback while this is high
- grant  out  NCORES  one-hot or zero; the core being serviced this cycle
- conflicts  out  16  saturating count of cycles with two or more requesters

## Operation
- req[i] = sharedMEM[i] & (tosharedRD[i] | tosharedWR[i]).
- Arbitration is round-robin from pointer rr (0..NCORES-1): grant the first req[i] at index rr, rr+1, … modulo NCORES. If no request is active, grant = 0.
- stall[i] = req[i] & ~grant[i]. All outputs in this list are combinational from the inputs and state.
- Word index = tosharedADDR[i][AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH. Bits [1:0] are ignored.
- Granted read (RD=1, WR=0): fromsharedDATA[i] = mem[index]. All non-granted ports read 0.
- Granted write (WR=1): mem[index] is updated to tosharedDATA[i] at the clock edge. If RD and WR are both high, the access is treated as a write and read data is 0.
- After a cycle with a grant to core g, rr is set to (g+1) mod NCORES. After a cycle with no grant, rr is unchanged.
- conflicts increments when popcount(req) ≥ 2 and saturates at 16'hFFFF.
- Fairness: a core that holds req continuously is granted within NCORES cycles.

## Timing
- Read latency is 0 cycles: data is valid in the grant cycle, in time for the core's same-cycle writeback.
- Write latency is 1 edge: a read of the same word by any core in the next cycle returns the new value.
- At most one access per cycle, so there is no intra-cycle read/write hazard.
- Reset (asynchronous) sets:
  - rr = 0
  - conflicts = 0
  - every mem word = 0
- While reset is high:
  - grant = 0
  - stall = req
  - fromsharedDATA = 0
  - no writes occur
- Reset asserted between edges aborts the in-flight write; that write is not committed.
- A core that drops its request while stalled simply loses arbitration. rr is not affected.

## Structure
- Package shared_mem_pkg holds:
  - NCORES_DEF
  - DEPTH_DEF
  - a word-index extraction function
  - a one-hot-to-index function
- Sub-module rr_arbiter(NCORES): clk, reset, req → grant. It owns rr and its update, and is reusable for other shared resources.
- The memory is a register array, because it must clear on reset. The top level holds the array, the mux/demux and the conflict counter.

## Test plan
- Single core: core 1 writes 32'hDEADBEEF to byte address 0x0000_0080; the next cycle core 1 reads it. Required: grant=4'b0010, stall=0 in both cycles, and read data 32'hDEADBEEF.
- Contention: all 4 cores hold read requests from reset. Required: grant sequence 0001, 0010, 0100, 1000, 0001; the stall of each non-granted core is high; conflicts reaches 4 after 4 cycles.
- Wrap and alias: write 32'h1234_5678 to address 0x100 (index 0 at DEPTH=64), then read address 0x000. Required: 32'h1234_5678.
- RD+WR together: core 2 asserts both strobes with data 32'hA5A5A5A5. Required: the word is written and fromsharedDATA for core 2 is 0 in that cycle.
- Skip and pointer hold: rr=2 with only core 0 requesting. Required: grant core 0 and rr becomes 1. An idle cycle follows. Required: rr stays 1.
- Reset mid-operation: assert reset between edges during core 3's write. Required:
  - the word stays 0
  - rr and conflicts are 0
  - a subsequent read returns 0
  - conflicts saturates at 16'hFFFF when forced past 65535 contention cycles
